// File: rtl/imem_pkg.sv
// imem_pkg: shared line-fill constants and responder state encoding used by the memory model and the cache address parser
package imem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, BURST, RESP} imem_state_e;
  localparam int CACHE_LINE = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_BITS = 2;
endpackage

// File: rtl/imem_word_ram.sv
// imem_word_ram: single-port word array (clk, we_i, wr_addr_i, wr_data_i, rd_addr_i, rd_data_o) with async read, sync write, write-priority address mux
module imem_word_ram #(
  parameter int WORDS = 16384,
  parameter int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);
  logic [31:0] mem_q [WORDS];
  logic [AW-1:0] addr;
  assign addr = we_i ? wr_addr_i : rd_addr_i;
  assign rd_data_o = mem_q[addr];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr] <= wr_data_i;
  end
endmodule

// File: rtl/imem_line_responder.sv
// imem_line_responder: line-fill responder (clk, rst, mem_req/mem_addr in, mem_data/mem_ready/busy out, ld_en/ld_addr/ld_data load port)
module imem_line_responder
  import imem_pkg::*;
#(
  parameter int MEM_WORDS = 16384,
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic [31:0]           mem_addr,
  output logic [CACHE_LINE-1:0] mem_data,
  output logic                  mem_ready,
  output logic                  busy,
  input  logic                  ld_en,
  input  logic [31:0]           ld_addr,
  input  logic [31:0]           ld_data
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  imem_state_e state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [1:0] beat_q, beat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CACHE_LINE-1:0] line_q, line_d;
  logic [31:0] rd_data;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};
  imem_word_ram #(.WORDS(MEM_WORDS)) u_ram (
    .clk       (clk),
    .we_i      (ld_en),
    .wr_addr_i (ld_addr[AW+1:2]),
    .wr_data_i (ld_data),
    .rd_addr_i (base_q | AW'(beat_q)),
    .rd_data_o (rd_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0;
      beat_q <= '0;
      cnt_q <= '0;
      line_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      beat_q <= beat_d;
      cnt_q <= cnt_d;
      line_q <= line_d;
    end
  end
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    beat_d = beat_q;
    cnt_d = cnt_q;
    line_d = line_q;
    case (state_q)
      IDLE: if (mem_req) begin
        state_d = LATENCY > 0 ? WAIT : BURST;
        base_d = mem_addr[AW+1:2] & ~AW'(WORDS_PER_LINE - 1);
        line_d = '0;
        cnt_d = CW'(LATENCY > 0 ? LATENCY - 1 : 0);
        beat_d = '0;
      end
      WAIT: if (!mem_req) state_d = IDLE;
        else if (cnt_q == '0) begin
          state_d = BURST;
          beat_d = '0;
        end else cnt_d = cnt_q - 1'b1;
      // a load this cycle owns the RAM address, so the beat waits and re-reads
      BURST: if (!mem_req) state_d = IDLE;
        else if (!ld_en) begin
          line_d[{beat_q, 5'd0} +: 32] = rd_data;
          beat_d = beat_q + 2'd1;
          state_d = beat_q == 2'd3 ? RESP : BURST;
        end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_ready = state_q == RESP;
    busy = state_q != IDLE;
    mem_data = line_q;
  end
endmodule

// File: tb/tb_imem_line_responder.sv
// tb_imem_line_responder: randomized self-checking bench against an array model of the backing store
module tb_imem_line_responder;
  logic clk = 0, rst = 1;
  logic req_a = 0, req_b = 0;
  logic [31:0] addr_a = 0, addr_b = 0;
  logic ld_en = 0;
  logic [31:0] ld_addr = 0, ld_data = 0;
  logic [127:0] data_a, data_b;
  logic rdy_a, rdy_b, busy_a, busy_b;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_a [16384];
  logic [31:0] m_b [64];
  always #5 clk = ~clk;
  imem_line_responder #(.MEM_WORDS(16384), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .mem_req(req_a), .mem_addr(addr_a), .mem_data(data_a),
    .mem_ready(rdy_a), .busy(busy_a), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
  imem_line_responder #(.MEM_WORDS(64), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .mem_req(req_b), .mem_addr(addr_b), .mem_data(data_b),
    .mem_ready(rdy_b), .busy(busy_b), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d);
    m_a[a[15:2]] = d;
    m_b[a[7:2]] = d;
  endfunction
  function automatic int base_of(input bit b, input logic [31:0] a);
    return (b ? int'(a[7:2]) : int'(a[15:2])) & ~3;
  endfunction
  function automatic logic [127:0] exp_line(input bit b, input logic [31:0] a);
    logic [127:0] r;
    int base;
    base = base_of(b, a);
    for (int k = 0; k < 4; k++) r[32*k +: 32] = b ? m_b[base+k] : m_a[base+k];
    return r;
  endfunction
  task automatic ld_word(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 0;
    model_wr(a, d);
  endtask
  task automatic do_line(input bit b, input logic [31:0] a, input int sb, input logic [31:0] sd, input bit keep);
    int lat, exp_n, n;
    bit got;
    logic [127:0] ed;
    logic [31:0] sa;
    lat = b ? 0 : 4;
    exp_n = 1 + lat + 4 + (sb >= 0 ? 1 : 0);
    if (b) begin req_b = 1; addr_b = a; end else begin req_a = 1; addr_a = a; end
    n_cmp++;
    if ((b ? busy_b : busy_a) !== 1'b0) begin n_bad++; $display("FAIL busy_idle dut%0d: got %b want 0", b, b ? busy_b : busy_a); end
    got = 0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      ld_en = 0;
      if (n == 1) begin if (b) addr_b = $urandom; else addr_a = $urandom; end
      if (sb >= 0 && n == 1 + lat + sb) begin
        sa = 32'(base_of(b, a) + sb) << 2;
        ld_en = 1;
        ld_addr = sa;
        ld_data = sd;
        model_wr(sa, sd);
      end
      n_cmp++;
      if ((b ? busy_b : busy_a) !== 1'b1) begin n_bad++; $display("FAIL busy_run dut%0d cyc %0d: got %b want 1", b, n, b ? busy_b : busy_a); end
      if ((b ? rdy_b : rdy_a) === 1'b1) got = 1;
    end
    ld_en = 0;
    n_cmp++;
    if (!got || n != exp_n) begin n_bad++; $display("FAIL latency dut%0d addr %h: got %0d want %0d", b, a, got ? n : -1, exp_n); end
    ed = exp_line(b, a);
    n_cmp++;
    if ((b ? data_b : data_a) !== ed) begin n_bad++; $display("FAIL data dut%0d addr %h: got %h want %h", b, a, b ? data_b : data_a, ed); end
    if (!keep) begin if (b) req_b = 0; else req_a = 0; end
    @(negedge clk);
    n_cmp++;
    if ((b ? rdy_b : rdy_a) !== 1'b0 || (b ? busy_b : busy_a) !== 1'b0) begin
      n_bad++; $display("FAIL post_resp dut%0d: got rdy %b busy %b want 0 0", b, b ? rdy_b : rdy_a, b ? busy_b : busy_a);
    end
    n_cmp++;
    if ((b ? data_b : data_a) !== ed) begin n_bad++; $display("FAIL data_hold dut%0d: got %h want %h", b, b ? data_b : data_a, ed); end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b %b want 0 0", rdy_a, rdy_b); end
    n_cmp++;
    if (data_a !== '0 || data_b !== '0) begin n_bad++; $display("FAIL reset_data: got %h %h want 0", data_a, data_b); end
    n_cmp++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b %b want 0 0", busy_a, busy_b); end
    rst = 0;
  endtask
  task automatic fill();
    for (int i = 0; i < 16384; i++) begin
      ld_en = 1;
      ld_addr = (32'(i) << 2) | 32'($urandom_range(0, 3));
      ld_data = $urandom;
      @(negedge clk);
      model_wr(ld_addr, ld_data);
    end
    ld_en = 0;
    for (int i = 0; i < 4; i++) ld_word(32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
  endtask
  task automatic test_basic();
    do_line(0, 32'h48, -1, 0, 0);
    n_cmp++;
    if (data_a !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      n_bad++; $display("FAIL basic_const: got %h want 000000a3000000a2000000a1000000a0", data_a);
    end
  endtask
  task automatic test_lat0();
    do_line(1, 32'h0, -1, 0, 0);
  endtask
  task automatic test_wrap();
    do_line(0, 32'h0001_0004, -1, 0, 0);
    do_line(1, 32'h0000_0104, -1, 0, 0);
  endtask
  task automatic test_random();
    repeat (8) do_line(1'($urandom_range(0, 1)), $urandom, -1, 0, 0);
  endtask
  task automatic test_back_to_back();
    do_line(0, $urandom, -1, 0, 1);
    do_line(0, $urandom, -1, 0, 0);
    do_line(1, $urandom, -1, 0, 1);
    do_line(1, $urandom, -1, 0, 0);
  endtask
  task automatic test_abandon();
    req_a = 1;
    addr_a = $urandom;
    repeat (2) @(negedge clk);
    req_a = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL abandon_ready cyc %0d: got %b want 0", k, rdy_a); end
      if (k == 2) begin
        n_cmp++;
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL abandon_busy: got %b want 0", busy_a); end
        n_cmp++;
        if (data_a !== '0) begin n_bad++; $display("FAIL abandon_data: got %h want 0", data_a); end
      end
    end
    do_line(0, $urandom, -1, 0, 0);
  endtask
  task automatic test_stall();
    do_line(0, $urandom, 1, 32'hDEAD, 0);
    n_cmp++;
    if (data_a[63:32] !== 32'hDEAD) begin n_bad++; $display("FAIL stall_slot1: got %h want 0000dead", data_a[63:32]); end
  endtask
  task automatic test_rst_mid();
    logic [31:0] a;
    a = $urandom;
    req_a = 1;
    addr_a = a;
    repeat (6) @(negedge clk);
    rst = 1;
    req_a = 0;
    @(negedge clk);
    rst = 0;
    n_cmp++;
    if (rdy_a !== 1'b0 || busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ctrl: got rdy %b busy %b want 0 0", rdy_a, busy_a); end
    n_cmp++;
    if (data_a !== '0) begin n_bad++; $display("FAIL rst_mid_data: got %h want 0", data_a); end
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 0", rdy_a); end
    end
    do_line(0, a, -1, 0, 0);
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    fill();
    test_basic();
    test_lat0();
    test_wrap();
    test_random();
    test_back_to_back();
    test_abandon();
    test_stall();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_line_responder.md
# imem_line_responder

Main-memory responder for the instruction cache's line-fill interface. It holds a word-addressed backing store and answers each `mem_req`/`mem_addr` request with a full 128-bit line on `mem_data` and a one-cycle `mem_ready` pulse. Response latency is configurable. A side load port lets the bench or boot logic write the program image.

## Interface
- `MEM_WORDS`, 16384: backing-store depth in 32-bit words; power of two, at least 4.
- `LATENCY`, 4: wait cycles inserted before the line burst; 0 is legal.
- `CACHE_LINE`, 128: line width in bits; fixed at 4 words.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_req`  in  1  line-fill request from the cache; held high until serviced or abandoned.
- `mem_addr`  in  32  byte address of the missed word.
- `mem_data`  out  128  returned line. Word k sits at bits [32k+31:32k].
- `mem_ready`  out  1  one-cycle pulse; `mem_data` is valid in that cycle.
- `busy`  out  1  high in every state except IDLE.
- `ld_en`  in  1  load-port write strobe.
- `ld_addr`  in  32  load byte address; bits [1:0] are ignored.
- `ld_data`  in  32  load word.

## Operation
- Word index = `addr[$clog2(MEM_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap modulo the store size.
- Line base = word index with the low 2 bits cleared. Beat k reads word base+k.
- FSM states: IDLE, WAIT, BURST, RESP.
  - IDLE: if `mem_req` is high, latch the line base and clear the line buffer. Go to WAIT if `LATENCY>0`, else BURST. Load the latency counter with `LATENCY-1`.
  - WAIT: decrement the counter each cycle. At 0, go to BURST with beat=0.
  - BURST: each cycle, capture word base+beat into buffer slot beat and increment the 2-bit beat. After beat 3, go to RESP.
  - RESP: drive `mem_ready=1` for one cycle, then go to IDLE.
- `mem_data` always reflects the line buffer. It keeps the last line until the next request is accepted.
- `mem_addr` is sampled only at acceptance. Later changes are ignored.
- Abandon: if `mem_req` is low in WAIT or BURST, return to IDLE next cycle. No `mem_ready` is issued and the buffer keeps its partial content.
- If `mem_req` is still high in the cycle after RESP, it is a new request. It is accepted from IDLE one cycle later.
- Load port:
  - A write completes at the clock edge in any state.
  - If `ld_en` is high in a BURST cycle, that beat stalls and beat does not advance. The read repeats next cycle and returns the newly written data if the address matches.
  - A load to a word already captured does not update the buffer.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values: `mem_ready=0`, `mem_data=0`, `busy=0`, state IDLE, beat 0, counter 0.
- Request first seen high in IDLE at cycle t: `mem_ready` is high in cycle t+1+LATENCY+4, assuming no load stalls. Default is t+9; with `LATENCY=0` it is t+5.
- Each load stall during BURST adds one cycle.
- `busy` goes high in cycle t+1 and drops in the cycle after RESP.
- `rst` mid-transaction: state goes to IDLE next cycle, no `mem_ready`, `mem_data` returns to 0.
- Reads are combinational from the array and captured at the clock edge. Writes take effect at the clock edge.

## Structure
- Shared package `imem_pkg`: state enum (IDLE, WAIT, BURST, RESP), `CACHE_LINE=128`, `WORDS_PER_LINE=4`, `OFFSET_BITS=2`. The cache's address parser uses the same constants.
- Sub-module `imem_word_ram`: single-port word array with asynchronous read, synchronous write, and write priority on a shared address mux. The FSM, counters and line buffer stay in the top module.

## Test plan
- Load words 0x10..0x13 with 0xA0,0xA1,0xA2,0xA3. Request `mem_addr=0x48` at cycle t → `mem_ready` high only in cycle t+9, `mem_data`=0x000000A3_000000A2_000000A1_000000A0.
- `LATENCY=0`, request `mem_addr=0x0` → `mem_ready` at t+5, data = words 0..3. `busy` is high for cycles t+1..t+5.
- `MEM_WORDS=16384`, request `mem_addr=0x0001_0004` → returns line words 0..3 (address wrap).
- Drop `mem_req` during WAIT → no `mem_ready`, `busy` low two cycles later. Next request is served normally.
- During BURST beat 1, write 0xDEAD to word base+1 → one-cycle stall, `mem_ready` at t+10, slot 1 = 0xDEAD.
- Assert `rst` during BURST → `mem_ready` stays 0, `mem_data`=0, FSM back in IDLE. Memory contents are preserved on a re-read.
